// File: rtl/frame_pkg.sv
// Shared constants and FSM state encoding for the SPI frame-buffer controller.
package frame_pkg;

    localparam int unsigned COLS_DEFAULT = 40;
    localparam int unsigned ROWS_DEFAULT = 15;
    localparam int unsigned ADDR_W       = 10;

    localparam logic [7:0] CMD_LOAD  = 8'hA5;
    localparam logic [7:0] CMD_CLEAR = 8'h5A;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCmd   = 3'd1,
        StLoad  = 3'd2,
        StClear = 3'd3,
        StDrain = 3'd4
    } state_e;

endpackage

// File: rtl/frame_addr_gen.sv
// Column/row cursor for the frame buffer with a running linear address
// (row*COLS+col) so no multiplier is needed.
module frame_addr_gen
    import frame_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              col_wrap;

    assign col_wrap = (col_q == ColW'(COLS - 1));
    assign last     = col_wrap && (row_q == RowW'(ROWS - 1));
    assign addr     = addr_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (inc) begin
            if (last) begin
                // Wrap the whole cursor so the address can never run past the frame.
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
            end else if (col_wrap) begin
                col_d  = '0;
                row_d  = row_q + RowW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                col_d  = col_q + ColW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI command decoder that loads or clears a COLS x ROWS character frame buffer
// and reports progress through a registered MISO status byte.
module spi_frame_ctrl
    import frame_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       msg_start,
    input  logic       msg_end,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] status
);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [7:0]        status_q, status_d;

    logic              gen_inc, gen_clr, gen_last;
    logic [ADDR_W-1:0] gen_addr;

    frame_addr_gen #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .inc  (gen_inc),
        .clr  (gen_clr),
        .addr (gen_addr),
        .last (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            status_q  <= status_d;
        end
    end

    // A byte arriving with msg_end is applied first; msg_end then acts on the
    // state that byte produced.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (msg_start) begin
                    state_d = StCmd;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            StCmd: begin
                if (byte_valid) begin
                    if (byte_data == CMD_LOAD) begin
                        state_d = StLoad;
                    end else if (byte_data == CMD_CLEAR) begin
                        state_d = StClear;
                    end else begin
                        state_d = StDrain;
                        err_d   = 1'b1;
                    end
                end
                if (msg_end && (state_d != StClear)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StLoad: begin
                if (byte_valid && gen_last) begin
                    state_d = StDrain;
                end
                if (msg_end) begin
                    if (state_d != StDrain) begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (gen_last) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (byte_valid) begin
                    ovf_d = 1'b1;
                end
                if (msg_start) begin
                    state_d = StCmd;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else if (msg_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        gen_inc   = 1'b0;
        gen_clr   = 1'b0;
        unique case (state_q)
            StCmd: begin
                gen_clr = byte_valid;
            end
            StLoad: begin
                if (byte_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = gen_addr;
                    wr_data_d = byte_data;
                    done_d    = gen_last;
                    gen_inc   = 1'b1;
                end
            end
            StClear: begin
                wr_en_d   = 1'b1;
                wr_addr_d = gen_addr;
                wr_data_d = FILL;
                done_d    = gen_last;
                gen_inc   = 1'b1;
            end
            default: begin
            end
        endcase
        busy_d   = (state_d != StIdle);
        status_d = {busy_d, err_d, ovf_d, 2'b00, state_d};
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;
    assign status     = status_q;

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 The block SHALL have parameter COLS, default 40, meaning frame width in characters.
REQ-002 The block SHALL have parameter ROWS, default 15, meaning frame height in characters.
REQ-003 The block SHALL have parameter FILL, default 8'h20, meaning the clear-fill character.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port byte_valid, input, 1, a one-cycle pulse marking a received SPI byte.
REQ-007 The block SHALL have port byte_data, input, 8, the received byte, qualified by byte_valid.
REQ-008 The block SHALL have port msg_start, input, 1, a one-cycle pulse on the SSEL falling edge.
REQ-009 The block SHALL have port msg_end, input, 1, a one-cycle pulse on the SSEL rising edge.
REQ-010 The block SHALL have port wr_en, output, 1, the frame-buffer write strobe.
REQ-011 The block SHALL have port wr_addr, output, 10, the write address, row*COLS+col.
REQ-012 The block SHALL have port wr_data, output, 8, the write data.
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse when a frame load or clear completes.
REQ-014 The block SHALL have port frame_err, output, 1, a sticky error flag cleared on the next msg_start.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 The block SHALL have port status, output, 8, the MISO reply byte {busy, frame_err, ovf, 2'b0, state[2:0]}.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, CMD, LOAD, CLEAR and DRAIN.
REQ-018 In IDLE, msg_start SHALL move the FSM to CMD and clear frame_err and ovf.
REQ-019 In CMD, the first byte_valid SHALL select the next state: 8'hA5 to LOAD with col=row=0; 8'h5A to CLEAR with col=row=0; any other value to DRAIN with frame_err=1.
REQ-020 In LOAD, each byte_valid SHALL produce wr_en=1 one cycle later, with wr_data=byte_data and wr_addr=row*COLS+col.
REQ-021 After each load write, col SHALL increment; when col=COLS-1 it SHALL wrap to 0 and row SHALL increment.
REQ-022 The write at address COLS*ROWS-1 SHALL pulse frame_done in the same cycle as that wr_en and move the FSM to DRAIN.
REQ-023 In CLEAR, the block SHALL write FILL to addresses 0..COLS*ROWS-1, one per cycle, ignoring byte_valid.
REQ-024 CLEAR SHALL pulse frame_done with the final write and then return to IDLE, even if msg_end occurred during the clear.
REQ-025 In DRAIN, byte_valid SHALL produce no write and SHALL set ovf=1.
REQ-026 In DRAIN, msg_end SHALL return the FSM to IDLE.
REQ-027 msg_end in CMD or LOAD before completion SHALL return the FSM to IDLE, set frame_err=1, and leave partial writes in place.
REQ-028 When byte_valid and msg_end coincide, the byte SHALL be processed first and msg_end applied afterwards.
REQ-029 msg_start outside IDLE SHALL be ignored, except in DRAIN, where it SHALL be treated as msg_end followed by a new start, giving CMD.
REQ-030 wr_addr SHALL never exceed COLS*ROWS-1, and wr_en SHALL be high for at most one cycle per address per frame.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE and wr_en, wr_addr, wr_data, frame_done, frame_err, ovf, busy, col and row SHALL all be 0.
REQ-033 status SHALL be 8'h00 while rst=1.
REQ-034 Reset asserted mid-LOAD or mid-CLEAR SHALL abort the operation with no write in the cycle following reset.

Structure
REQ-035 Package frame_pkg SHALL hold COLS and ROWS defaults, CMD_LOAD=8'hA5, CMD_CLEAR=8'h5A, and the state enum encoding (IDLE=0, CMD=1, LOAD=2, CLEAR=3, DRAIN=4).
REQ-036 One sub-module, frame_addr_gen, SHALL hold the col/row counters with inc/clr inputs and addr/last outputs.

Verification
REQ-037 start, then 0xA5, then 600 bytes 0x00..0x57 (mod 256) -> 600 writes, addr 0..599, single frame_done with addr 599, frame_err=0.
REQ-038 start, then 0x5A, then immediate msg_end -> 600 consecutive-cycle writes of 8'h20, frame_done, then IDLE with busy=0.
REQ-039 start, then 0xA5, then 10 bytes, then msg_end -> writes addr 0..9, frame_err=1, no frame_done, status[6]=1.
REQ-040 start, then 0x33, then 3 bytes, then end -> no writes, frame_err=1, ovf=1, IDLE.
REQ-041 rst pulsed during LOAD at addr 300 -> no write after reset; the next 0xA5 frame restarts at addr 0.
REQ-042 In LOAD, the 600th byte_valid coincides with msg_end -> addr 599 written, frame_done=1, frame_err=0.
